// File: rtl/lexer_pkg.sv
// Shared types and constants for the keyword lexer and the downstream nesting checker.
package lexer_pkg;

    typedef enum logic [1:0] {
        TOK_OTHER = 2'b00,
        TOK_BEGIN = 2'b01,
        TOK_END   = 2'b10
    } tok_kind_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_B1,
        ST_B2,
        ST_B3,
        ST_B4,
        ST_B5,
        ST_E1,
        ST_E2,
        ST_E3,
        ST_OTH
    } lexer_state_t;

    localparam logic [7:0] ASCII_UA       = 8'h41;
    localparam logic [7:0] ASCII_UZ       = 8'h5A;
    localparam logic [7:0] ASCII_LA       = 8'h61;
    localparam logic [7:0] ASCII_LZ       = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    localparam logic [7:0] KW_B = 8'h62;
    localparam logic [7:0] KW_E = 8'h65;
    localparam logic [7:0] KW_G = 8'h67;
    localparam logic [7:0] KW_I = 8'h69;
    localparam logic [7:0] KW_N = 8'h6E;
    localparam logic [7:0] KW_D = 8'h64;

    // Token kind reported when a word ends in the given state.
    function automatic tok_kind_t kind_of(lexer_state_t s);
        case (s)
            ST_B5:   return TOK_BEGIN;
            ST_E3:   return TOK_END;
            default: return TOK_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/ascii_classifier.sv
// Combinational letter detection and case folding for the keyword lexer.
// KW_LEXER_CASE_SENSITIVE_EN disables folding; letter classification is unaffected.
module ascii_classifier
    import lexer_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_letter,
    output logic [7:0] folded
);

    logic is_upper;
    logic is_lower;

    assign is_upper  = (ch >= ASCII_UA) && (ch <= ASCII_UZ);
    assign is_lower  = (ch >= ASCII_LA) && (ch <= ASCII_LZ);
    assign is_letter = is_upper || is_lower;

`ifdef KW_LEXER_CASE_SENSITIVE_EN
    assign folded = ch;
`else
    assign folded = is_upper ? (ch | ASCII_CASE_BIT) : ch;
`endif

endmodule

// File: rtl/keyword_lexer.sv
// Splits a character stream into words and emits BEGIN/END/OTHER tokens with saturated lengths.
// Build option: KW_LEXER_CASE_SENSITIVE_EN (handled in ascii_classifier).
module keyword_lexer
    import lexer_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in,
    input  logic             flush,
    output logic             tok_valid,
    output logic [1:0]       tok_kind,
    output logic [LEN_W-1:0] tok_len,
    output logic             in_word
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    lexer_state_t     state;
    lexer_state_t     state_next;
    lexer_state_t     st_after;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] len_after;
    logic             is_letter;
    logic [7:0]       folded;
    logic             terminate;
    logic             tok_valid_c;
    tok_kind_t        tok_kind_c;
    logic [LEN_W-1:0] tok_len_c;

    ascii_classifier u_classifier (
        .ch        (in),
        .is_letter (is_letter),
        .folded    (folded)
    );

    // State and length register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            len   <= '0;
        end else begin
            state <= state_next;
            len   <= len_next;
        end
    end

    // Effect of the current letter (if any), before word termination is applied.
    always_comb begin
        st_after  = state;
        len_after = len;
        if (in_valid && is_letter) begin
            len_after = (len == LEN_MAX) ? len : len + LEN_W'(1);
            case (state)
                ST_IDLE: st_after = (folded == KW_B) ? ST_B1 :
                                    (folded == KW_E) ? ST_E1 : ST_OTH;
                ST_B1:   st_after = (folded == KW_E) ? ST_B2 : ST_OTH;
                ST_B2:   st_after = (folded == KW_G) ? ST_B3 : ST_OTH;
                ST_B3:   st_after = (folded == KW_I) ? ST_B4 : ST_OTH;
                ST_B4:   st_after = (folded == KW_N) ? ST_B5 : ST_OTH;
                ST_E1:   st_after = (folded == KW_N) ? ST_E2 : ST_OTH;
                ST_E2:   st_after = (folded == KW_D) ? ST_E3 : ST_OTH;
                default: st_after = ST_OTH;
            endcase
        end
    end

    // A delimiter or flush closes the word after the current letter is absorbed.
    assign terminate = flush || (in_valid && !is_letter);

    // Next-state logic.
    always_comb begin
        state_next = st_after;
        len_next   = len_after;
        if (terminate) begin
            state_next = ST_IDLE;
            len_next   = '0;
        end
    end

    // Token decode.
    always_comb begin
        tok_valid_c = 1'b0;
        tok_kind_c  = kind_of(st_after);
        tok_len_c   = len_after;
        if (terminate && (st_after != ST_IDLE)) begin
            tok_valid_c = 1'b1;
        end
    end

    // Output registers; token fields hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            tok_valid <= 1'b0;
            tok_kind  <= 2'b00;
            tok_len   <= '0;
            in_word   <= 1'b0;
        end else begin
            tok_valid <= tok_valid_c;
            in_word   <= (state_next != ST_IDLE);
            if (tok_valid_c) begin
                tok_kind <= tok_kind_c;
                tok_len  <= tok_len_c;
            end
        end
    end

endmodule

// File: tb/tb_keyword_lexer.sv
// Scoreboard bench for keyword_lexer: two instances (LEN_W=8 and LEN_W=2) share one stimulus stream.
module tb_keyword_lexer;
    import lexer_pkg::*;

    typedef struct {
        logic [1:0] kind;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in = 8'h00;
    logic       flush = 1'b0;

    logic       tok_valid_a;
    logic [1:0] tok_kind_a;
    logic [7:0] tok_len_a;
    logic       in_word_a;
    logic       tok_valid_b;
    logic [1:0] tok_kind_b;
    logic [1:0] tok_len_b;
    logic       in_word_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    keyword_lexer #(.LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in),
        .flush     (flush),
        .tok_valid (tok_valid_a),
        .tok_kind  (tok_kind_a),
        .tok_len   (tok_len_a),
        .in_word   (in_word_a)
    );

    keyword_lexer #(.LEN_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in),
        .flush     (flush),
        .tok_valid (tok_valid_b),
        .tok_kind  (tok_kind_b),
        .tok_len   (tok_len_b),
        .in_word   (in_word_b)
    );

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Monitor: every token pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (tok_valid_a) begin
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_token_w8 kind=%0d len=%0d (no token expected)", tok_kind_a, tok_len_a);
            end else begin
                e = q_a.pop_front();
                if (tok_kind_a !== e.kind || int'(tok_len_a) !== sat(e.len, 255)) begin
                    n_fail++;
                    $display("FAIL token_w8 got kind=%0d len=%0d, expected kind=%0d len=%0d",
                             tok_kind_a, tok_len_a, e.kind, sat(e.len, 255));
                end
            end
        end
        if (tok_valid_b) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_token_w2 kind=%0d len=%0d (no token expected)", tok_kind_b, tok_len_b);
            end else begin
                e = q_b.pop_front();
                if (tok_kind_b !== e.kind || int'(tok_len_b) !== sat(e.len, 3)) begin
                    n_fail++;
                    $display("FAIL token_w2 got kind=%0d len=%0d, expected kind=%0d len=%0d",
                             tok_kind_b, tok_len_b, e.kind, sat(e.len, 3));
                end
            end
        end
    end

    task automatic expect_tok(input logic [1:0] kind, input int len);
        exp_t e;
        e.kind = kind;
        e.len  = len;
        q_a.push_back(e);
        q_b.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c, input logic f);
        in_valid = v;
        in       = c;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] k_begin;
        logic [1:0] k_end;
`ifdef KW_LEXER_CASE_SENSITIVE_EN
        k_begin = 2'b00;
        k_end   = 2'b00;
`else
        k_begin = 2'b01;
        k_end   = 2'b10;
`endif
        @(posedge clk);
        #1;
        do_reset();
        check("reset_tok_valid", int'(tok_valid_a), 0);
        check("reset_tok_kind", int'(tok_kind_a), 0);
        check("reset_tok_len", int'(tok_len_a), 0);
        check("reset_in_word", int'(in_word_a), 0);
        check("reset_in_word_w2", int'(in_word_b), 0);

        // Lowercase begin, token one cycle after the delimiter
        expect_tok(2'b01, 5);
        send_str("begin");
        check("in_word_open", int'(in_word_a), 1);
        check("no_tok_before_delim", int'(tok_valid_a), 0);
        send_str(" ");
        check("begin_latency_pulse", int'(tok_valid_a), 1);
        check("in_word_after_delim", int'(in_word_a), 0);
        step(1'b0, 8'h00, 1'b0);
        check("pulse_one_cycle", int'(tok_valid_a), 0);

        // Mixed-case keywords
        expect_tok(k_begin, 5);
        expect_tok(k_end, 3);
        send_str("BEgIn.eNd,");

        // Near-keywords and repeated delimiters
        expect_tok(2'b00, 4);
        expect_tok(2'b00, 6);
        send_str("ends ");
        send_str(" ");
        check("in_word_between", int'(in_word_a), 0);
        send_str("beginx,,");
        check("in_word_after_dd", int'(in_word_a), 0);

        // Back-to-back single-letter words
        expect_tok(2'b00, 1);
        expect_tok(2'b00, 1);
        send_str("a.b.");

        // Stall then flush carrying the last letter
        expect_tok(2'b10, 3);
        send_str("en");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h41, 1'b0);
            check("stall_in_word", int'(in_word_a), 1);
            check("stall_no_tok", int'(tok_valid_a), 0);
        end
        step(1'b1, "d", 1'b1);
        check("flush_letter_tok", int'(tok_valid_a), 1);
        check("flush_in_word", int'(in_word_a), 0);

        // Flush in IDLE gives nothing; flush with a delimiter gives one token
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, " ", 1'b1);
        expect_tok(2'b00, 1);
        send_str("a");
        step(1'b1, ",", 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Saturation: 7 letters (w2 saturates at 3), 300 letters (w8 saturates at 255)
        expect_tok(2'b00, 7);
        send_str("abcdefg ");
        expect_tok(2'b00, 300);
        for (int i = 0; i < 300; i++) step(1'b1, "z", 1'b0);
        send_str(".");

        // Reset mid-word discards it
        expect_tok(2'b10, 3);
        send_str("be");
        do_reset();
        check("reset_mid_in_word", int'(in_word_a), 0);
        check("reset_mid_tok_valid", int'(tok_valid_a), 0);
        send_str(" end ");

        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        check("queue_drained_w8", q_a.size(), 0);
        check("queue_drained_w2", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
